// File: rtl/x_memxbar_ord.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : x_memxbar_ord
// Brief    : Address-interleaved memory crossbar. One main request port is
//            steered to N_CH channel controllers by the low SEL_W address
//            bits. Read data is returned to the main port in issue order.
// Options  : X_MEMXBAR_ORD_ERR_EN adds a sticky o_err output that flags
//            spurious or overlapping channel responses.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module x_memxbar_ord #(
    parameter  int N_CH   = 8,
    parameter  int CH_AW  = 16,
    parameter  int DW     = 8,
    parameter  int OT_MAX = 8,
    localparam int SEL_W  = $clog2(N_CH),
    localparam int MAW    = CH_AW + SEL_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_main_valid,
    output logic                o_main_accept,
    input  logic                i_main_rd_n_wr,
    input  logic [MAW-1:0]      i_main_addr,
    input  logic [DW-1:0]       i_main_wdata,
    output logic                o_main_ready,
    output logic [DW-1:0]       o_main_rdata,
    output logic [N_CH-1:0]     o_ch_valid,
    input  logic [N_CH-1:0]     i_ch_accept,
    output logic                o_ch_rd_n_wr,
    output logic [CH_AW-1:0]    o_ch_addr,
    output logic [DW-1:0]       o_ch_wdata,
    input  logic [N_CH-1:0]     i_ch_ready,
`ifdef X_MEMXBAR_ORD_ERR_EN
    output logic                o_err,
`endif
    input  logic [N_CH*DW-1:0]  i_ch_rdata
);

    // Order FIFO pointers wrap at OT_MAX; storage is sized to N_CH so that a
    // SEL_W-bit pointer indexes it exactly.
    localparam logic [SEL_W:0]   c_OT_MAX   = (SEL_W+1)'(OT_MAX);
    localparam logic [SEL_W-1:0] c_PTR_LAST = SEL_W'(OT_MAX - 1);

    logic [SEL_W-1:0] r_fifo [N_CH];
    logic [SEL_W-1:0] r_wptr;
    logic [SEL_W-1:0] r_rptr;
    logic [SEL_W:0]   r_count;

    logic [N_CH-1:0]  r_pend;
    logic [N_CH-1:0]  r_hold_v;
    logic [DW-1:0]    r_hold_d [N_CH];

    logic [SEL_W-1:0] w_sel;
    logic [SEL_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_stall;
    logic             w_push;
    logic             w_pop;
    logic [DW-1:0]    w_pop_data;
    logic [DW-1:0]    w_ch_rdata [N_CH];
    logic [N_CH-1:0]  w_head_oh;
    logic [N_CH-1:0]  w_resp_ok;
    logic [N_CH-1:0]  w_capture;
    logic [N_CH-1:0]  w_clr;
    logic [N_CH-1:0]  w_set_pend;

    // ------------------------------------------------------------------
    // Request path: purely combinational, no added latency.
    // ------------------------------------------------------------------
    assign w_sel   = i_main_addr[SEL_W-1:0];
    assign w_full  = (r_count == c_OT_MAX);
    assign w_empty = (r_count == '0);
    // A channel with a read in flight blocks every request to it; a full
    // order FIFO blocks reads only.
    assign w_stall = r_pend[w_sel] | (i_main_rd_n_wr & w_full);

    assign o_main_accept = |(o_ch_valid & i_ch_accept);
    assign o_ch_rd_n_wr  = i_main_rd_n_wr;
    assign o_ch_addr     = i_main_addr[MAW-1:SEL_W];
    assign o_ch_wdata    = i_main_wdata;

    assign w_push = o_main_accept & i_main_rd_n_wr;
    assign w_head = r_fifo[r_rptr];

    // The head either has buffered data or is answering right now (bypass).
    assign w_pop      = |w_clr;
    assign w_pop_data = r_hold_v[w_head] ? r_hold_d[w_head] : w_ch_rdata[w_head];

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic          r_pend_q;
            logic          r_hold_v_q;
            logic [DW-1:0] r_hold_d_q;

            assign w_ch_rdata[c] = i_ch_rdata[c*DW +: DW];
            assign o_ch_valid[c] = i_main_valid & (w_sel == SEL_W'(c)) & ~w_stall;
            assign w_set_pend[c] = w_push & (w_sel == SEL_W'(c));
            assign w_head_oh[c]  = ~w_empty & (w_head == SEL_W'(c));
            // Only a response to an outstanding, not-yet-buffered read counts.
            assign w_resp_ok[c]  = i_ch_ready[c] & r_pend_q & ~r_hold_v_q;
            assign w_capture[c]  = w_resp_ok[c] & ~w_head_oh[c];
            assign w_clr[c]      = w_head_oh[c] & (r_hold_v_q | w_resp_ok[c]);

            assign r_pend[c]   = r_pend_q;
            assign r_hold_v[c] = r_hold_v_q;
            assign r_hold_d[c] = r_hold_d_q;

            // Per-channel outstanding flag and early-response holding buffer.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    r_pend_q   <= 1'b0;
                    r_hold_v_q <= 1'b0;
                    r_hold_d_q <= '0;
                end else begin
                    if (w_clr[c])
                        r_pend_q <= 1'b0;
                    else if (w_set_pend[c])
                        r_pend_q <= 1'b1;

                    if (w_clr[c])
                        r_hold_v_q <= 1'b0;
                    else if (w_capture[c])
                        r_hold_v_q <= 1'b1;

                    if (w_capture[c])
                        r_hold_d_q <= w_ch_rdata[c];
                end
            end
        end
    endgenerate

    // Order FIFO storage; contents are meaningless while count is zero.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_fifo[r_wptr] <= w_sel;
    end

    // Order FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Return stage: one-cycle ready pulse, data held between returns.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_main_ready <= 1'b0;
            o_main_rdata <= '0;
        end else begin
            o_main_ready <= w_pop;
            if (w_pop)
                o_main_rdata <= w_pop_data;
        end
    end

`ifdef X_MEMXBAR_ORD_ERR_EN
    logic r_err;

    // Sticky flag: response with nothing outstanding or overrunning a buffer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_err <= 1'b0;
        else if (|(i_ch_ready & (~r_pend | r_hold_v)))
            r_err <= 1'b1;
    end

    assign o_err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_x_memxbar_ord.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_x_memxbar_ord
// Brief    : Self-checking bench for x_memxbar_ord. Read data expected on the
//            main port is queued at request acceptance and checked in order
//            whenever the DUT pulses o_main_ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_memxbar_ord;

    localparam int N_CH  = 8;
    localparam int CH_AW = 16;
    localparam int DW    = 8;
    localparam int SEL_W = 3;
    localparam int MAW   = CH_AW + SEL_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main DUT (OT_MAX = 8)
    logic              main_valid, main_accept, main_rd_n_wr, main_ready;
    logic [MAW-1:0]    main_addr;
    logic [DW-1:0]     main_wdata, main_rdata;
    logic [N_CH-1:0]   ch_valid, ch_accept, ch_ready;
    logic              ch_rd_n_wr;
    logic [CH_AW-1:0]  ch_addr;
    logic [DW-1:0]     ch_wdata;
    logic [N_CH*DW-1:0] ch_rdata;
    logic              err;

    // Second DUT (OT_MAX = 2) for the full-FIFO case
    logic              b_valid, b_accept, b_rd_n_wr, b_ready;
    logic [MAW-1:0]    b_addr;
    logic [DW-1:0]     b_wdata, b_rdata;
    logic [N_CH-1:0]   b_ch_valid, b_ch_ready;
    logic              b_ch_rd_n_wr;
    logic [CH_AW-1:0]  b_ch_addr;
    logic [DW-1:0]     b_ch_wdata;
    logic [N_CH*DW-1:0] b_ch_rdata;
    logic              b_err;

    x_memxbar_ord dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_main_valid(main_valid), .o_main_accept(main_accept),
        .i_main_rd_n_wr(main_rd_n_wr), .i_main_addr(main_addr),
        .i_main_wdata(main_wdata), .o_main_ready(main_ready),
        .o_main_rdata(main_rdata), .o_ch_valid(ch_valid),
        .i_ch_accept(ch_accept), .o_ch_rd_n_wr(ch_rd_n_wr),
        .o_ch_addr(ch_addr), .o_ch_wdata(ch_wdata),
        .i_ch_ready(ch_ready),
`ifdef X_MEMXBAR_ORD_ERR_EN
        .o_err(err),
`endif
        .i_ch_rdata(ch_rdata)
    );

    x_memxbar_ord #(.OT_MAX(2)) dut2 (
        .i_clk(clk), .i_rst(rst_n),
        .i_main_valid(b_valid), .o_main_accept(b_accept),
        .i_main_rd_n_wr(b_rd_n_wr), .i_main_addr(b_addr),
        .i_main_wdata(b_wdata), .o_main_ready(b_ready),
        .o_main_rdata(b_rdata), .o_ch_valid(b_ch_valid),
        .i_ch_accept(8'hFF), .o_ch_rd_n_wr(b_ch_rd_n_wr),
        .o_ch_addr(b_ch_addr), .o_ch_wdata(b_ch_wdata),
        .i_ch_ready(b_ch_ready),
`ifdef X_MEMXBAR_ORD_ERR_EN
        .o_err(b_err),
`endif
        .i_ch_rdata(b_ch_rdata)
    );

`ifndef X_MEMXBAR_ORD_ERR_EN
    assign err   = 1'b0;
    assign b_err = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ch_data [N_CH];

    // Scoreboard: every ready pulse must match the oldest queued read.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst_n === 1'b1 && main_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_ready: got rdata=%h, required no ready", main_rdata);
            end else begin
                e = exp_q.pop_front();
                if (main_rdata !== e) begin
                    n_errors++;
                    $display("FAIL sb_rdata: got %h, required %h", main_rdata, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the main DUT, hold until accepted (bounded).
    task automatic issue(input bit rd, input logic [MAW-1:0] addr, input logic [DW-1:0] wd);
        bit done = 1'b0;
        main_valid = 1'b1; main_rd_n_wr = rd; main_addr = addr; main_wdata = wd;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (main_accept === 1'b1) begin
                done = 1'b1;
                if (rd) exp_q.push_back(ch_data[addr[SEL_W-1:0]]);
            end
            @(posedge clk);
            #1;
        end
        main_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL issue_timeout addr=%h: accept=0, required 1 within 20 cycles", addr);
        end
    endtask

    task automatic respond(input int c);
        ch_ready = 8'(1 << c);
        ch_rdata[c*DW +: DW] = ch_data[c];
        cyc();
        ch_ready = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) cyc();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: got %0d reads unreturned, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (main_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b, required 0", main_ready); end
        n_checks++; if (main_rdata !== 8'h00) begin n_errors++; $display("FAIL rst_rdata: got %h, required 00", main_rdata); end
        n_checks++; if (ch_valid !== 8'h00) begin n_errors++; $display("FAIL rst_ch_valid: got %h, required 00", ch_valid); end
        main_valid = 1'b1; main_rd_n_wr = 1'b0; main_addr = 19'h00003; ch_accept = 8'h00;
        #1;
        n_checks++; if (ch_valid !== 8'h08) begin n_errors++; $display("FAIL rst_comb_valid: got %h, required 08", ch_valid); end
        n_checks++; if (main_accept !== 1'b0) begin n_errors++; $display("FAIL rst_comb_acc0: got %b, required 0", main_accept); end
        ch_accept = 8'hFF;
        #1;
        n_checks++; if (main_accept !== 1'b1) begin n_errors++; $display("FAIL rst_comb_acc1: got %b, required 1", main_accept); end
        main_valid = 1'b0;
`ifdef X_MEMXBAR_ORD_ERR_EN
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b, required 0", err); end
`endif
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_write();
        main_valid = 1'b1; main_rd_n_wr = 1'b0; main_addr = 19'h00005; main_wdata = 8'h3C;
        ch_accept = 8'hDF;
        #1;
        n_checks++; if (main_accept !== 1'b0) begin n_errors++; $display("FAIL wr_noacc: got %b, required 0", main_accept); end
        ch_accept = 8'hFF;
        #1;
        n_checks++; if (ch_valid !== 8'h20) begin n_errors++; $display("FAIL wr_ch_valid: got %h, required 20", ch_valid); end
        n_checks++; if (ch_addr !== 16'h0000) begin n_errors++; $display("FAIL wr_ch_addr: got %h, required 0000", ch_addr); end
        n_checks++; if (main_accept !== 1'b1) begin n_errors++; $display("FAIL wr_accept: got %b, required 1", main_accept); end
        n_checks++; if ({ch_rd_n_wr, ch_wdata} !== 9'h03C) begin n_errors++; $display("FAIL wr_payload: got %h, required 03c", {ch_rd_n_wr, ch_wdata}); end
        cyc();
        main_valid = 1'b0;
        #1;
        n_checks++; if (main_ready !== 1'b0) begin n_errors++; $display("FAIL wr_no_ready: got %b, required 0", main_ready); end
        cyc();
    endtask

    task automatic test_order();
        ch_data[2] = 8'h52; ch_data[6] = 8'hA6;
        issue(1'b1, {16'h0012, 3'd2}, 8'h00);
        issue(1'b1, {16'h0034, 3'd6}, 8'h00);
        respond(6);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (main_ready !== 1'b0) begin n_errors++; $display("FAIL ord_held_%0d: got ready=%b, required 0", k, main_ready); end
            cyc();
        end
        respond(2);
        #1;
        n_checks++; if ({main_ready, main_rdata} !== 9'h152) begin n_errors++; $display("FAIL ord_first: got %h, required 152", {main_ready, main_rdata}); end
        cyc();
        #1;
        n_checks++; if ({main_ready, main_rdata} !== 9'h1A6) begin n_errors++; $display("FAIL ord_second: got %h, required 1a6", {main_ready, main_rdata}); end
        cyc();
        #1;
        n_checks++; if ({main_ready, main_rdata} !== 9'h0A6) begin n_errors++; $display("FAIL ord_idle_hold: got %h, required 0a6", {main_ready, main_rdata}); end
        wait_drain("order");
    endtask

    task automatic test_stall_pending();
        ch_data[3] = 8'h33;
        issue(1'b1, 19'h00003, 8'h00);
        main_valid = 1'b1; main_rd_n_wr = 1'b0; main_addr = 19'h00043; main_wdata = 8'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if ({ch_valid, main_accept} !== 9'h000) begin n_errors++; $display("FAIL pend_stall_%0d: got %h, required 000", k, {ch_valid, main_accept}); end
            cyc();
        end
        ch_ready = 8'h08; ch_rdata[3*DW +: DW] = ch_data[3];
        #1;
        n_checks++; if (main_accept !== 1'b0) begin n_errors++; $display("FAIL pend_pop_cycle: got accept=%b, required 0", main_accept); end
        cyc();
        ch_ready = '0;
        #1;
        n_checks++; if ({main_ready, main_rdata} !== 9'h133) begin n_errors++; $display("FAIL pend_return: got %h, required 133", {main_ready, main_rdata}); end
        n_checks++; if ({ch_valid, main_accept} !== 9'h011) begin n_errors++; $display("FAIL pend_released: got %h, required 011", {ch_valid, main_accept}); end
        n_checks++; if (ch_addr !== 16'h0008) begin n_errors++; $display("FAIL pend_ch_addr: got %h, required 0008", ch_addr); end
        cyc();
        main_valid = 1'b0;
        wait_drain("pend");
    endtask

    task automatic test_full();
        b_valid = 1'b1; b_rd_n_wr = 1'b1; b_addr = 19'h00000;
        #1;
        n_checks++; if (b_accept !== 1'b1) begin n_errors++; $display("FAIL full_rd0: got %b, required 1", b_accept); end
        cyc();
        b_addr = 19'h00001;
        #1;
        n_checks++; if (b_accept !== 1'b1) begin n_errors++; $display("FAIL full_rd1: got %b, required 1", b_accept); end
        cyc();
        b_addr = 19'h00004;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if ({b_ch_valid, b_accept} !== 9'h000) begin n_errors++; $display("FAIL full_rd4_stall_%0d: got %h, required 000", k, {b_ch_valid, b_accept}); end
            cyc();
        end
        b_rd_n_wr = 1'b0; b_wdata = 8'h44;
        #1;
        n_checks++; if ({b_ch_valid, b_accept} !== 9'h021) begin n_errors++; $display("FAIL full_wr4: got %h, required 021", {b_ch_valid, b_accept}); end
        cyc();
        b_rd_n_wr = 1'b1;
        b_ch_ready = 8'h01; b_ch_rdata[0 +: DW] = 8'h10;
        #1;
        n_checks++; if (b_accept !== 1'b0) begin n_errors++; $display("FAIL full_pop_cycle: got %b, required 0", b_accept); end
        cyc();
        b_ch_ready = '0;
        #1;
        n_checks++; if ({b_ready, b_rdata} !== 9'h110) begin n_errors++; $display("FAIL full_ret0: got %h, required 110", {b_ready, b_rdata}); end
        n_checks++; if (b_accept !== 1'b1) begin n_errors++; $display("FAIL full_rd4_after: got %b, required 1", b_accept); end
        cyc();
        b_valid = 1'b0;
        // Head (ch1) answers together with ch4: bypass plus hold, back to back.
        b_ch_ready = 8'h12; b_ch_rdata[1*DW +: DW] = 8'h11; b_ch_rdata[4*DW +: DW] = 8'h14;
        cyc();
        b_ch_ready = '0;
        #1;
        n_checks++; if ({b_ready, b_rdata} !== 9'h111) begin n_errors++; $display("FAIL full_ret1: got %h, required 111", {b_ready, b_rdata}); end
        cyc();
        #1;
        n_checks++; if ({b_ready, b_rdata} !== 9'h114) begin n_errors++; $display("FAIL full_ret4: got %h, required 114", {b_ready, b_rdata}); end
        cyc();
    endtask

    task automatic test_reset_mid();
        ch_data[1] = 8'h61; ch_data[2] = 8'h62; ch_data[3] = 8'h63;
        issue(1'b1, 19'h00001, 8'h00);
        issue(1'b1, 19'h00002, 8'h00);
        issue(1'b1, 19'h00003, 8'h00);
        respond(1);
        #1;
        n_checks++; if ({main_ready, main_rdata} !== 9'h161) begin n_errors++; $display("FAIL rmid_pre: got %h, required 161", {main_ready, main_rdata}); end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++; if ({main_ready, main_rdata} !== 9'h000) begin n_errors++; $display("FAIL rmid_async: got %h, required 000", {main_ready, main_rdata}); end
`ifdef X_MEMXBAR_ORD_ERR_EN
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rmid_err_clr: got %b, required 0", err); end
`endif
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        ch_ready = 8'h0C;
        cyc();
        ch_ready = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (main_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_spurious_%0d: got ready=%b, required 0", k, main_ready); end
            cyc();
        end
`ifdef X_MEMXBAR_ORD_ERR_EN
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL rmid_err_set: got %b, required 1", err); end
`endif
        main_valid = 1'b1; main_rd_n_wr = 1'b1; main_addr = 19'h00002;
        #1;
        n_checks++; if (main_accept !== 1'b1) begin n_errors++; $display("FAIL rmid_reaccept: got %b, required 1", main_accept); end
        if (main_accept === 1'b1) exp_q.push_back(ch_data[2]);
        cyc();
        main_valid = 1'b0;
        respond(2);
        wait_drain("rmid");
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < N_CH; c++) ch_data[c] = 8'hB0 + 8'(c);
        for (int k = 0; k < 12; k++) begin
            main_valid = (k < 8); main_rd_n_wr = 1'b1; main_addr = MAW'(k % 8);
            if (k >= 2 && k < 10) begin
                ch_ready = 8'(1 << (k - 2));
                ch_rdata[(k-2)*DW +: DW] = ch_data[k-2];
            end else begin
                ch_ready = '0;
            end
            #1;
            if (k < 8) begin
                n_checks++; if (main_accept !== 1'b1) begin n_errors++; $display("FAIL b2b_accept_%0d: got %b, required 1", k, main_accept); end
                if (main_accept === 1'b1) exp_q.push_back(ch_data[k]);
            end
            if (k >= 3 && k <= 10) begin
                n_checks++; if (main_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_%0d: got %b, required 1", k, main_ready); end
            end
            if (k == 11) begin
                n_checks++; if (main_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_tail: got %b, required 0", main_ready); end
            end
            cyc();
        end
        main_valid = 1'b0; ch_ready = '0;
        wait_drain("b2b");
    endtask

    initial begin
        rst_n = 1'b0;
        main_valid = 1'b0; main_rd_n_wr = 1'b0; main_addr = '0; main_wdata = '0;
        ch_accept = 8'hFF; ch_ready = '0; ch_rdata = '0;
        b_valid = 1'b0; b_rd_n_wr = 1'b0; b_addr = '0; b_wdata = '0;
        b_ch_ready = '0; b_ch_rdata = '0;
        for (int c = 0; c < N_CH; c++) ch_data[c] = 8'h00;
        test_reset();
        test_write();
        test_order();
        test_stall_pending();
        test_full();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
